// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with tear-free load,
// leading-zero blanking and inter-digit blank gaps.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    blank_lz,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [6:0]              segs,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_done
);

  localparam int DW   = 4 * NUM_DIGITS;
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] T_SHOW = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] T_GAP  = TW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  state_t          state, nxt_state;
  logic [IW-1:0]   idx, nxt_idx;
  logic [TW-1:0]   timer, nxt_timer;
  logic [DW-1:0]   active, nxt_active;
  logic [DW-1:0]   pending, nxt_pend;
  logic            pending_vld, nxt_pvld;
  logic [DW-1:0]   upper;
  logic [3:0]      nib;
  logic            lz;

  function automatic logic [6:0] dec7seg(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    nxt_state  = state;
    nxt_idx    = idx;
    nxt_timer  = timer;
    nxt_active = active;
    nxt_pend   = pending;
    nxt_pvld   = pending_vld;
    if (load_valid && load_ready) begin
      nxt_pend = load_data;
      nxt_pvld = 1'b1;
    end
    if (!enable) begin
      nxt_state = IDLE;
      nxt_idx   = '0;
      nxt_timer = '0;
    end else begin
      unique case (state)
        IDLE: begin
          nxt_state = SHOW;
          nxt_idx   = '0;
          nxt_timer = '0;
        end
        SHOW: begin
          if (timer == T_SHOW) begin
            nxt_state = GAP;
            nxt_timer = '0;
          end else begin
            nxt_timer = timer + TW'(1);
          end
        end
        GAP: begin
          if (timer == T_GAP) begin
            nxt_state = SHOW;
            nxt_timer = '0;
            if (idx == LAST) begin
              nxt_idx = '0;
              // ready is low whenever pending is full, so no clash with a new load
              if (pending_vld) begin
                nxt_active = pending;
                nxt_pvld   = 1'b0;
              end
            end else begin
              nxt_idx = idx + IW'(1);
            end
          end else begin
            nxt_timer = timer + TW'(1);
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_idx   = '0;
          nxt_timer = '0;
        end
      endcase
    end
    upper = nxt_active >> {nxt_idx, 2'b00};
    nib   = upper[3:0];
    lz    = blank_lz && (nxt_idx != '0) && (upper == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      active      <= '0;
      pending     <= '0;
      pending_vld <= 1'b0;
      segs        <= 7'h7F;
      digit_en_n  <= '1;
      load_ready  <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state       <= nxt_state;
      idx         <= nxt_idx;
      timer       <= nxt_timer;
      active      <= nxt_active;
      pending     <= nxt_pend;
      pending_vld <= nxt_pvld;
      load_ready  <= ~nxt_pvld;
      frame_done  <= (nxt_state == GAP) && (nxt_idx == LAST) &&
                     (nxt_timer == T_GAP);
      if (nxt_state == SHOW) begin
        digit_en_n <= ~(NUM_DIGITS'(1) << nxt_idx);
        segs       <= lz ? 7'h7F : dec7seg(nib);
      end else begin
        digit_en_n <= '1;
        segs       <= 7'h7F;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits,
// dwell 3 and blank 1 (16-cycle frame).
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        blank_lz;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [6:0]  segs;
  logic [3:0]  digit_en_n;
  logic        frame_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (4),
    .DWELL_CYCLES(3),
    .BLANK_CYCLES(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .blank_lz  (blank_lz),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .segs      (segs),
    .digit_en_n(digit_en_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task test_reset;
    rst_n      = 1'b0;
    enable     = 1'b1;
    blank_lz   = 1'b0;
    load_valid = 1'b1;
    load_data  = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (segs !== 7'h7F) $display("FAIL rst_segs got %h exp 7f", segs);
    else pass_cnt++;
    total_cnt++;
    if (digit_en_n !== 4'hF) $display("FAIL rst_en got %h exp f", digit_en_n);
    else pass_cnt++;
    total_cnt++;
    if (load_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", load_ready);
    else pass_cnt++;
    total_cnt++;
    if (frame_done !== 1'b0) $display("FAIL rst_fd got %b exp 0", frame_done);
    else pass_cnt++;
    rst_n      = 1'b1;
    load_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (segs !== 7'h40 || digit_en_n !== 4'hE)
      $display("FAIL rst_active got %h/%h exp 40/e", segs, digit_en_n);
    else pass_cnt++;
    enable = 1'b0;
    @(negedge clk);
  endtask

  task test_scan;
    logic [6:0] tab [4];
    logic [6:0] es;
    logic [3:0] ee;
    int slot, d;
    logic show;
    tab = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    load_valid = 1'b1;
    load_data  = 16'h12AF;
    @(negedge clk);
    load_valid = 1'b0;
    total_cnt++;
    if (load_ready !== 1'b0) $display("FAIL scan_ld_ready got %b exp 0", load_ready);
    else pass_cnt++;
    enable = 1'b1;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      slot = n % 16;
      d    = slot / 4;
      show = (slot % 4) < 3;
      es   = !show ? 7'h7F : (n < 16 ? 7'h40 : tab[d]);
      ee   = show ? 4'(~(4'b0001 << d)) : 4'hF;
      total_cnt++;
      if (segs !== es) $display("FAIL scan_segs n=%0d got %h exp %h", n, segs, es);
      else pass_cnt++;
      total_cnt++;
      if (digit_en_n !== ee) $display("FAIL scan_en n=%0d got %h exp %h", n, digit_en_n, ee);
      else pass_cnt++;
      total_cnt++;
      if (frame_done !== (slot == 15))
        $display("FAIL scan_fd n=%0d got %b exp %b", n, frame_done, slot == 15);
      else pass_cnt++;
      total_cnt++;
      if (load_ready !== (n >= 16))
        $display("FAIL scan_ready n=%0d got %b exp %b", n, load_ready, n >= 16);
      else pass_cnt++;
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task test_leading_zeros;
    logic [6:0] es;
    logic [3:0] ee;
    int slot, d;
    logic show;
    blank_lz   = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h0005;
    @(negedge clk);
    load_valid = 1'b0;
    enable     = 1'b1;
    for (int n = 0; n < 48; n++) begin
      @(negedge clk);
      slot = n % 16;
      d    = slot / 4;
      show = (slot % 4) < 3;
      if (n >= 16) begin
        if (!show || d != 0) es = 7'h7F;
        else es = (n < 32) ? 7'b0010010 : 7'b1000000;
        ee = show ? 4'(~(4'b0001 << d)) : 4'hF;
        total_cnt++;
        if (segs !== es) $display("FAIL lz_segs n=%0d got %h exp %h", n, segs, es);
        else pass_cnt++;
        total_cnt++;
        if (digit_en_n !== ee) $display("FAIL lz_en n=%0d got %h exp %h", n, digit_en_n, ee);
        else pass_cnt++;
      end
      if (n == 20) begin
        load_valid = 1'b1;
        load_data  = 16'h0000;
      end
      if (n == 21) load_valid = 1'b0;
    end
    enable   = 1'b0;
    blank_lz = 1'b0;
    @(negedge clk);
  endtask

  task test_tear_free;
    logic [6:0] es;
    logic [3:0] ee;
    logic er;
    int slot, d;
    logic show;
    load_valid = 1'b1;
    load_data  = 16'h1111;
    @(negedge clk);
    load_valid = 1'b0;
    enable     = 1'b1;
    for (int n = 0; n < 48; n++) begin
      @(negedge clk);
      slot = n % 16;
      d    = slot / 4;
      show = (slot % 4) < 3;
      if (!show) es = 7'h7F;
      else if (n < 16) es = 7'b1000000;
      else if (n < 32) es = 7'b1111001;
      else es = 7'b0110000;
      ee = show ? 4'(~(4'b0001 << d)) : 4'hF;
      er = !(n < 16 || (n >= 21 && n < 32));
      total_cnt++;
      if (segs !== es) $display("FAIL tear_segs n=%0d got %h exp %h", n, segs, es);
      else pass_cnt++;
      total_cnt++;
      if (digit_en_n !== ee) $display("FAIL tear_en n=%0d got %h exp %h", n, digit_en_n, ee);
      else pass_cnt++;
      total_cnt++;
      if (load_ready !== er) $display("FAIL tear_ready n=%0d got %b exp %b", n, load_ready, er);
      else pass_cnt++;
      if (n == 20) begin
        load_valid = 1'b1;
        load_data  = 16'h3333;
      end
      if (n == 21) load_valid = 1'b0;
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task test_disable;
    enable = 1'b1;
    for (int n = 0; n < 10; n++) @(negedge clk);
    total_cnt++;
    if (segs !== 7'b0110000 || digit_en_n !== 4'hB)
      $display("FAIL dis_digit2 got %h/%h exp 30/b", segs, digit_en_n);
    else pass_cnt++;
    enable = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      total_cnt++;
      if (segs !== 7'h7F || digit_en_n !== 4'hF || frame_done !== 1'b0)
        $display("FAIL dis_dark n=%0d got %h/%h/%b exp 7f/f/0",
                 n, segs, digit_en_n, frame_done);
      else pass_cnt++;
    end
    enable = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (segs !== 7'b0110000 || digit_en_n !== 4'hE)
      $display("FAIL dis_reenable got %h/%h exp 30/e", segs, digit_en_n);
    else pass_cnt++;
    enable = 1'b0;
    @(negedge clk);
  endtask

  task test_reset_pending;
    logic [6:0] es;
    logic [3:0] ee;
    int slot, d;
    logic show;
    enable = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n == 3) begin
        load_valid = 1'b1;
        load_data  = 16'h5A5A;
      end
      if (n == 4) load_valid = 1'b0;
    end
    total_cnt++;
    if (load_ready !== 1'b0) $display("FAIL rp_ready_pre got %b exp 0", load_ready);
    else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (load_ready !== 1'b1 || digit_en_n !== 4'hF)
      $display("FAIL rp_in_reset got %b/%h exp 1/f", load_ready, digit_en_n);
    else pass_cnt++;
    rst_n = 1'b1;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      slot = n % 16;
      d    = slot / 4;
      show = (slot % 4) < 3;
      es   = show ? 7'b1000000 : 7'h7F;
      ee   = show ? 4'(~(4'b0001 << d)) : 4'hF;
      total_cnt++;
      if (segs !== es) $display("FAIL rp_segs n=%0d got %h exp %h", n, segs, es);
      else pass_cnt++;
      total_cnt++;
      if (digit_en_n !== ee) $display("FAIL rp_en n=%0d got %h exp %h", n, digit_en_n, ee);
      else pass_cnt++;
      total_cnt++;
      if (load_ready !== 1'b1) $display("FAIL rp_ready n=%0d got %b exp 1", n, load_ready);
      else pass_cnt++;
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_leading_zeros();
    test_tear_free();
    test_disable();
    test_reset_pending();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
